// File: rtl/sub_thirty_two_bit_seq_if.sv
// Operand/result handshake bundle for the sequential 32-bit subtractor.
// The master drives operands and done_ready; the slave returns results.
interface sub_thirty_two_bit_seq_if;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;
  logic        neg;
  logic        done_valid;
  logic        done_ready;

  modport master (
    output start_valid, a, b, bin, done_ready,
    input  start_ready, diff, bout, ovf, zero, neg, done_valid
  );

  modport slave (
    input  start_valid, a, b, bin, done_ready,
    output start_ready, diff, bout, ovf, zero, neg, done_valid
  );
endinterface

// File: rtl/sub_thirty_two_bit_seq.sv
// Multi-cycle 32-bit subtractor: diff = a - b - bin, one SLICE_W-bit slice per
// clock through a registered borrow chain, with valid/ready on both sides.
module sub_thirty_two_bit_seq #(
  parameter int unsigned SLICE_W = 8
) (
  input logic                      clk,
  input logic                      rst,
  sub_thirty_two_bit_seq_if.slave  bus
);

  localparam int unsigned N     = 32 / SLICE_W;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic [SLICE_W:0]   slice_sum;

  // Subtraction as a + ~b + ~borrow; the slice carry-out is the inverted borrow.
  assign slice_sum = {1'b0, a_q[idx_q*SLICE_W +: SLICE_W]}
                   + {1'b0, ~b_q[idx_q*SLICE_W +: SLICE_W]}
                   + {{SLICE_W{1'b0}}, ~borrow_q};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;

    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d[idx_q*SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
        borrow_d = ~slice_sum[SLICE_W];
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N - 1)) begin
          // Visible results change only here, on entry to DONE.
          state_d = DONE;
          diff_d  = acc_d;
          bout_d  = ~slice_sum[SLICE_W];
          ovf_d   = (a_q[31] != b_q[31]) && (acc_d[31] != a_q[31]);
          zero_d  = (acc_d == 32'd0);
          neg_d   = acc_d[31];
        end
      end
      DONE: begin
        if (bus.done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.done_valid  = (state_q == DONE);
  assign bus.diff        = diff_q;
  assign bus.bout        = bout_q;
  assign bus.ovf         = ovf_q;
  assign bus.zero        = zero_q;
  assign bus.neg         = neg_q;

endmodule

// File: tb/tb_sub_thirty_two_bit_seq.sv
// Bench for sub_thirty_two_bit_seq at SLICE_W = 4, 8 and 16 against an
// arithmetic reference model, with directed corner cases and random operands.
module tb_sub_thirty_two_bit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_r = '0;
  logic [31:0] b_r = '0;
  logic        bin_r = 1'b0;
  logic        sv [3];
  logic        dr [3];

  logic [31:0] diff_w [3];
  logic        bout_w [3];
  logic        ovf_w  [3];
  logic        zero_w [3];
  logic        neg_w  [3];
  logic        sr_w   [3];
  logic        dv_w   [3];

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_diff [3];

  always #5 clk = ~clk;

  sub_thirty_two_bit_seq_if ifs [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign ifs[g].a           = a_r;
    assign ifs[g].b           = b_r;
    assign ifs[g].bin         = bin_r;
    assign ifs[g].start_valid = sv[g];
    assign ifs[g].done_ready  = dr[g];
    assign diff_w[g] = ifs[g].diff;
    assign bout_w[g] = ifs[g].bout;
    assign ovf_w[g]  = ifs[g].ovf;
    assign zero_w[g] = ifs[g].zero;
    assign neg_w[g]  = ifs[g].neg;
    assign sr_w[g]   = ifs[g].start_ready;
    assign dv_w[g]   = ifs[g].done_valid;

    sub_thirty_two_bit_seq #(.SLICE_W(4 << g)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifs[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: 33-bit unsigned subtraction; ovf from the sign rule on a, b, diff.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       output logic [31:0] d, output logic bo, output logic ov,
                       output logic z, output logic ng);
    logic [32:0] r;
    r  = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    d  = r[31:0];
    bo = r[32];
    ov = (a[31] != b[31]) && (d[31] != a[31]);
    z  = (d == 32'd0);
    ng = d[31];
  endtask

  task automatic chk_results(input int sel, input logic [31:0] a, input logic [31:0] b,
                             input logic bin, input string tag);
    logic [31:0] d;
    logic bo, ov, z, ng;
    model(a, b, bin, d, bo, ov, z, ng);
    chk({tag, ".diff"}, diff_w[sel], d);
    chk({tag, ".bout"}, {31'd0, bout_w[sel]}, {31'd0, bo});
    chk({tag, ".ovf"},  {31'd0, ovf_w[sel]},  {31'd0, ov});
    chk({tag, ".zero"}, {31'd0, zero_w[sel]}, {31'd0, z});
    chk({tag, ".neg"},  {31'd0, neg_w[sel]},  {31'd0, ng});
  endtask

  // Called at posedge+1; leaves the DUT in DONE with done_ready low.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input string tag);
    int n;
    int k;
    n = 32 / (4 << sel);
    a_r = a; b_r = b; bin_r = bin;
    sv[sel] = 1'b1;
    chk({tag, ".start_ready"}, {31'd0, sr_w[sel]}, 32'd1);
    @(posedge clk); #1;
    sv[sel] = 1'b0;
    a_r = ~a; b_r = ~b; bin_r = ~bin;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (dv_w[sel]) break;
      if (diff_w[sel] !== prev_diff[sel]) chk({tag, ".held_diff"}, diff_w[sel], prev_diff[sel]);
    end
    chk({tag, ".latency"}, k, n);
    chk_results(sel, a, b, bin, tag);
    prev_diff[sel] = diff_w[sel];
  endtask

  task automatic finish_op(input int sel, input string tag);
    dr[sel] = 1'b1;
    @(posedge clk); #1;
    dr[sel] = 1'b0;
    chk({tag, ".dv_drop"}, {31'd0, dv_w[sel]}, 32'd0);
    chk({tag, ".ready_back"}, {31'd0, sr_w[sel]}, 32'd1);
  endtask

  localparam int NDIR = 8;
  logic [31:0] dir_a   [NDIR] = '{32'd5, 32'd0, 32'h100, 32'h12345678, 32'h12345678,
                                  32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
  logic [31:0] dir_b   [NDIR] = '{32'd3, 32'd1, 32'd1, 32'h12345678, 32'h12345678,
                                  32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic        dir_bin [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    for (int s = 0; s < 3; s++) begin
      sv[s] = 1'b0; dr[s] = 1'b0; prev_diff[s] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("reset.start_ready", {31'd0, sr_w[s]}, 32'd1);
      chk("reset.done_valid", {31'd0, dv_w[s]}, 32'd0);
      chk("reset.flags", {27'd0, diff_w[s] != 0, bout_w[s], ovf_w[s], zero_w[s], neg_w[s]}, 32'd0);
    end
    rst = 1'b0;

    for (int s = 0; s < 3; s++) begin
      string w;
      logic [31:0] exp_d;
      logic bo, ov, z, ng;
      w = $sformatf("w%0d", 4 << s);

      for (int i = 0; i < NDIR; i++) begin
        run_op(s, dir_a[i], dir_b[i], dir_bin[i], $sformatf("%s.dir%0d", w, i));
        finish_op(s, $sformatf("%s.dir%0d", w, i));
      end

      for (int i = 0; i < 15; i++) begin
        logic [31:0] ra, rb;
        ra = $urandom;
        rb = (i % 4 == 0) ? ra : $urandom;
        run_op(s, ra, rb, 1'($urandom_range(1, 0)), $sformatf("%s.rnd%0d", w, i));
        finish_op(s, $sformatf("%s.rnd%0d", w, i));
      end

      // Stall in DONE while a new request with changing operands is offered.
      run_op(s, 32'h0000_1234, 32'h0000_0235, 1'b1, {w, ".stall"});
      model(32'h0000_1234, 32'h0000_0235, 1'b1, exp_d, bo, ov, z, ng);
      sv[s] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        a_r = $urandom; b_r = $urandom;
        @(posedge clk); #1;
        chk({w, ".stall.diff"}, diff_w[s], exp_d);
        chk({w, ".stall.dv"}, {31'd0, dv_w[s]}, 32'd1);
        chk({w, ".stall.sr"}, {31'd0, sr_w[s]}, 32'd0);
      end
      sv[s] = 1'b0;
      finish_op(s, {w, ".stall"});
      @(posedge clk); #1;
      chk({w, ".stall.no_accept"}, {31'd0, sr_w[s]}, 32'd1);

      // Reset during the second RUN cycle aborts the operation.
      run_op(s, 32'd5, 32'd3, 1'b0, {w, ".pre_rst"});
      finish_op(s, {w, ".pre_rst"});
      a_r = 32'hDEAD_BEEF; b_r = 32'h0000_0001; bin_r = 1'b0;
      sv[s] = 1'b1;
      @(posedge clk); #1;
      sv[s] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk({w, ".rst.sr"}, {31'd0, sr_w[s]}, 32'd1);
      chk({w, ".rst.diff"}, diff_w[s], 32'd0);
      chk({w, ".rst.bout"}, {31'd0, bout_w[s]}, 32'd0);
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        if (dv_w[s] !== 1'b0) chk({w, ".rst.no_done"}, {31'd0, dv_w[s]}, 32'd0);
      end
      chk({w, ".rst.idle_after"}, {31'd0, dv_w[s]}, 32'd0);
      for (int t = 0; t < 3; t++) prev_diff[t] = diff_w[t];
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
